// File: rtl/alu_pkg.sv
// Shared types and encodings for the ID->EX decode stage.
package alu_pkg;

    // ALU operation codes as seen by the EX-stage ALU
    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_LUI  = 4'h9,
        ALU_SLTU = 4'hA
    } alu_op_t;

    // Immediate formats produced by imm_gen
    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,      // {instr[31:12], 12'b0}
        IMM_LUI,    // {12'b0, instr[31:12]}, ALU applies the <<12
        IMM_J,
        IMM_SHAMT
    } imm_type_t;

    // Decoded control held in the pipeline register
    typedef struct packed {
        alu_op_t op;
        logic    op1_sel;
        logic    op2_sel;
        logic    illegal;
    } ctrl_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Base funct3 -> ALU op mapping shared by OP and OP-IMM
    function automatic alu_op_t f3_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extraction for all RV32I immediate formats.
module imm_gen
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [31:7]           instr,
    input  imm_type_t             imm_type,
    output logic [DATA_WIDTH-1:0] imm
);

    logic [31:0] raw;

    // Build the 32-bit immediate for the selected format
    always_comb begin
        raw = '0;
        case (imm_type)
            IMM_I:     raw = {{20{instr[31]}}, instr[31:20]};
            IMM_S:     raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:     raw = {instr[31:12], 12'b0};
            IMM_LUI:   raw = {12'b0, instr[31:12]};
            IMM_J:     raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_SHAMT: raw = {27'b0, instr[24:20]};
            default:   raw = '0;
        endcase
    end

    assign imm = DATA_WIDTH'($signed(raw));

endmodule

// File: rtl/alu_decode_stage.sv
// Registered ID->EX decode stage: decodes RV32I into ALU control, holds it in a
// valid/ready pipeline register and counts accepted illegal instructions.
module alu_decode_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          SLTU_EN    = 1'b0,
    parameter int unsigned ILL_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            ALUctrl,
    output logic                  op1_sel,
    output logic                  op2_sel,
    output logic [DATA_WIDTH-1:0] imm_out,
    output logic                  illegal,
    output logic [ILL_CNT_W-1:0]  ill_count
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    ctrl_t                 dec;
    imm_type_t             dec_imm_type;
    logic [DATA_WIDTH-1:0] dec_imm;

    ctrl_t                 ctrl_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic                  valid_q;
    logic [ILL_CNT_W-1:0]  cnt_q;
    logic                  accept;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    // Decode opcode/funct3/funct7 into ALU control and immediate format
    always_comb begin
        dec.op       = ALU_ADD;
        dec.op1_sel  = 1'b0;
        dec.op2_sel  = 1'b0;
        dec.illegal  = 1'b0;
        dec_imm_type = IMM_NONE;
        case (opcode)
            OPC_OP: begin
                dec.op = f3_op(f3);
                case (f3)
                    3'b000: begin
                        if (f7 == F7_ALT)       dec.op = ALU_SUB;
                        else if (f7 != F7_BASE) dec.illegal = 1'b1;
                    end
                    3'b101: begin
                        if (f7 == F7_ALT)       dec.op = ALU_SRA;
                        else if (f7 != F7_BASE) dec.illegal = 1'b1;
                    end
                    default: begin
                        if (f7 != F7_BASE) dec.illegal = 1'b1;
                    end
                endcase
                if (f3 == 3'b011 && !SLTU_EN) dec.illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.op       = f3_op(f3);
                dec.op2_sel  = 1'b1;
                dec_imm_type = IMM_I;
                case (f3)
                    3'b001: begin
                        dec_imm_type = IMM_SHAMT;
                        if (f7 != F7_BASE) dec.illegal = 1'b1;
                    end
                    3'b101: begin
                        dec_imm_type = IMM_SHAMT;
                        if (f7 == F7_ALT)       dec.op = ALU_SRA;
                        else if (f7 != F7_BASE) dec.illegal = 1'b1;
                    end
                    default: ;
                endcase
                if (f3 == 3'b011 && !SLTU_EN) dec.illegal = 1'b1;
            end
            OPC_LOAD: begin
                dec.op2_sel  = 1'b1;
                dec_imm_type = IMM_I;
            end
            OPC_STORE: begin
                dec.op2_sel  = 1'b1;
                dec_imm_type = IMM_S;
            end
            OPC_BRANCH: begin
                dec.op       = ALU_SUB;
                dec_imm_type = IMM_B;
            end
            OPC_LUI: begin
                dec.op       = ALU_LUI;
                dec.op2_sel  = 1'b1;
                dec_imm_type = IMM_LUI;
            end
            OPC_AUIPC: begin
                dec.op1_sel  = 1'b1;
                dec.op2_sel  = 1'b1;
                dec_imm_type = IMM_U;
            end
            OPC_JAL: begin
                dec.op1_sel  = 1'b1;
                dec.op2_sel  = 1'b1;
                dec_imm_type = IMM_J;
            end
            OPC_JALR: begin
                dec.op2_sel  = 1'b1;
                dec_imm_type = IMM_I;
            end
            default: dec.illegal = 1'b1;
        endcase
        // Illegal instructions carry a clean all-zero payload to EX
        if (dec.illegal) begin
            dec.op       = ALU_ADD;
            dec.op1_sel  = 1'b0;
            dec.op2_sel  = 1'b0;
            dec_imm_type = IMM_NONE;
        end
    end

    imm_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_imm_gen (
        .instr    (instr[31:7]),
        .imm_type (dec_imm_type),
        .imm      (dec_imm)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Pipeline register with valid/ready handshake; flush wins over accept and stall
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            imm_q   <= '0;
            cnt_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            ctrl_q  <= dec;
            imm_q   <= dec_imm;
            if (dec.illegal && cnt_q != '1) cnt_q <= cnt_q + ILL_CNT_W'(1);
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign ALUctrl   = ctrl_q.op;
    assign op1_sel   = ctrl_q.op1_sel;
    assign op2_sel   = ctrl_q.op2_sel;
    assign illegal   = ctrl_q.illegal;
    assign imm_out   = imm_q;
    assign ill_count = cnt_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: scoreboard of expected decodes
// popped on each EX handshake, plus scenario tasks with inline checks.
module tb_alu_decode_stage;

    typedef struct packed {
        logic [3:0]  alu;
        logic        op1;
        logic        op2;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  alu_ctrl;
    logic        op1_sel;
    logic        op2_sel;
    logic [31:0] imm_out;
    logic        illegal;
    logic [7:0]  ill_count;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [31:0] instr2 = '0;
    logic        out_valid2;
    logic        out_ready2 = 1'b1;
    logic [3:0]  alu_ctrl2;
    logic        op1_sel2;
    logic        op2_sel2;
    logic [31:0] imm_out2;
    logic        illegal2;
    logic [1:0]  ill_count2;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_decode_stage #(
        .DATA_WIDTH (32),
        .SLTU_EN    (1'b0),
        .ILL_CNT_W  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUctrl   (alu_ctrl),
        .op1_sel   (op1_sel),
        .op2_sel   (op2_sel),
        .imm_out   (imm_out),
        .illegal   (illegal),
        .ill_count (ill_count)
    );

    alu_decode_stage #(
        .DATA_WIDTH (32),
        .SLTU_EN    (1'b1),
        .ILL_CNT_W  (2)
    ) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .instr     (instr2),
        .flush     (flush),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .ALUctrl   (alu_ctrl2),
        .op1_sel   (op1_sel2),
        .op2_sel   (op2_sel2),
        .imm_out   (imm_out2),
        .illegal   (illegal2),
        .ill_count (ill_count2)
    );

    // Scoreboard: every EX handshake on the main DUT pops one expected decode
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got alu=%0h imm=%08h with no expected entry", alu_ctrl, imm_out);
            end else begin
                e = exp_q.pop_front();
                if ({alu_ctrl, op1_sel, op2_sel, imm_out, illegal} !== e) begin
                    errors++;
                    $display("FAIL sb_decode: got alu=%0h op1=%0b op2=%0b imm=%08h ill=%0b, expected alu=%0h op1=%0b op2=%0b imm=%08h ill=%0b",
                             alu_ctrl, op1_sel, op2_sel, imm_out, illegal, e.alu, e.op1, e.op2, e.imm, e.ill);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Offer one instruction, wait (bounded) for in_ready, record its expectation
    task automatic send(input logic [31:0] w, input exp_t e);
        int n;
        in_valid = 1'b1;
        instr    = w;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1 for instr %08h", in_ready, w);
        end else begin
            exp_q.push_back(e);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
        checks++; if (alu_ctrl !== 4'h0)    begin errors++; $display("FAIL reset_aluctrl: got %0h required 0", alu_ctrl); end
        checks++; if (imm_out !== 32'h0)    begin errors++; $display("FAIL reset_imm: got %08h required 0", imm_out); end
        checks++; if (ill_count !== 8'h0)   begin errors++; $display("FAIL reset_ill_count: got %0d required 0", ill_count); end
        checks++; if ({op1_sel, op2_sel, illegal} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %03b required 000", {op1_sel, op2_sel, illegal}); end
        checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
        checks++; if (out_valid2 !== 1'b0 || ill_count2 !== 2'd0) begin errors++; $display("FAIL reset_sat_dut: got valid=%0b cnt=%0d required 0/0", out_valid2, ill_count2); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_sub();
        send(32'h40208033, '{4'h1, 1'b0, 1'b0, 32'h0, 1'b0});
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sub_valid: got %0b required 1", out_valid); end
        checks++; if (alu_ctrl !== 4'h1 || op2_sel !== 1'b0 || illegal !== 1'b0) begin
            errors++; $display("FAIL sub_decode: got alu=%0h op2=%0b ill=%0b required 1/0/0", alu_ctrl, op2_sel, illegal);
        end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sub_drain: out_valid got %0b required 0", out_valid); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        send(32'h4030D093, '{4'h7, 1'b0, 1'b1, 32'h3, 1'b0});
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            instr    = 32'hFFF00093;
            checks++;
            if (out_valid !== 1'b1 || alu_ctrl !== 4'h7 || imm_out !== 32'h3 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d got valid=%0b alu=%0h imm=%08h in_ready=%0b required 1/7/00000003/0",
                         i, out_valid, alu_ctrl, imm_out, in_ready);
            end
            step();
        end
        exp_q.push_back('{4'h0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0});
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || alu_ctrl !== 4'h0 || imm_out !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL stall_release: got valid=%0b alu=%0h imm=%08h required 1/0/ffffffff", out_valid, alu_ctrl, imm_out);
        end
        step();
    endtask

    task automatic test_sltu_flush();
        exp_t junk;
        send(32'h0020B033, '{4'h0, 1'b0, 1'b0, 32'h0, 1'b1});
        checks++; if (illegal !== 1'b1 || ill_count !== 8'd1) begin
            errors++; $display("FAIL sltu_illegal: got ill=%0b cnt=%0d required 1/1", illegal, ill_count);
        end
        step();
        in_valid = 1'b1; instr = 32'h0020B033; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || ill_count !== 8'd1) begin
            errors++; $display("FAIL flush_drop: got valid=%0b cnt=%0d required 0/1", out_valid, ill_count);
        end
        out_ready = 1'b0;
        send(32'h123450B7, '{4'h9, 1'b0, 1'b1, 32'h00012345, 1'b0});
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_held: out_valid got %0b required 1", out_valid); end
        flush = 1'b1; in_valid = 1'b1; instr = 32'h0020B033;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || ill_count !== 8'd1) begin
            errors++; $display("FAIL flush_held: got valid=%0b cnt=%0d required 0/1", out_valid, ill_count);
        end
        junk = exp_q.pop_back();
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [13];
        exp_t        ex  [13];
        ins[0]  = 32'h123450B7; ex[0]  = '{4'h9, 1'b0, 1'b1, 32'h00012345, 1'b0};
        ins[1]  = 32'hFFF00093; ex[1]  = '{4'h0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0};
        ins[2]  = 32'hFE20AE23; ex[2]  = '{4'h0, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b0};
        ins[3]  = 32'hFE208CE3; ex[3]  = '{4'h1, 1'b0, 1'b0, 32'hFFFFFFF8, 1'b0};
        ins[4]  = 32'h12345097; ex[4]  = '{4'h0, 1'b1, 1'b1, 32'h12345000, 1'b0};
        ins[5]  = 32'h001000EF; ex[5]  = '{4'h0, 1'b1, 1'b1, 32'h00000800, 1'b0};
        ins[6]  = 32'hFF0100E7; ex[6]  = '{4'h0, 1'b0, 1'b1, 32'hFFFFFFF0, 1'b0};
        ins[7]  = 32'h0020F1B3; ex[7]  = '{4'h2, 1'b0, 1'b0, 32'h0, 1'b0};
        ins[8]  = 32'h4020D0B3; ex[8]  = '{4'h7, 1'b0, 1'b0, 32'h0, 1'b0};
        ins[9]  = 32'h01F09093; ex[9]  = '{4'h5, 1'b0, 1'b1, 32'h0000001F, 1'b0};
        ins[10] = 32'h02208033; ex[10] = '{4'h0, 1'b0, 1'b0, 32'h0, 1'b1};
        ins[11] = 32'h0020A0B3; ex[11] = '{4'h8, 1'b0, 1'b0, 32'h0, 1'b0};
        ins[12] = 32'hFFF0C093; ex[12] = '{4'h4, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0};
        for (int i = 0; i < 13; i++) send(ins[i], ex[i]);
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: out_valid got %0b required 0", out_valid); end
        checks++; if (ill_count !== 8'd2) begin errors++; $display("FAIL b2b_ill_count: got %0d required 2", ill_count); end
    endtask

    task automatic test_reset_mid_stall();
        exp_t junk;
        out_ready = 1'b0;
        send(32'h0020F1B3, '{4'h2, 1'b0, 1'b0, 32'h0, 1'b0});
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || alu_ctrl !== 4'h0 || ill_count !== 8'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_stall: got valid=%0b alu=%0h cnt=%0d in_ready=%0b required 0/0/0/1",
                     out_valid, alu_ctrl, ill_count, in_ready);
        end
        junk = exp_q.pop_back();
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_saturate();
        logic [1:0] want;
        for (int i = 0; i < 5; i++) begin
            in_valid2 = 1'b1;
            instr2    = 32'h00000000;
            step();
            want = (i < 3) ? 2'(i + 1) : 2'd3;
            checks++;
            if (ill_count2 !== want || illegal2 !== 1'b1) begin
                errors++;
                $display("FAIL saturate_%0d: got cnt=%0d ill=%0b required %0d/1", i, ill_count2, illegal2, want);
            end
        end
        instr2 = 32'h0020B033;
        step();
        in_valid2 = 1'b0;
        checks++;
        if (alu_ctrl2 !== 4'hA || illegal2 !== 1'b0 || op2_sel2 !== 1'b0 || ill_count2 !== 2'd3 || in_ready2 !== 1'b1) begin
            errors++;
            $display("FAIL sltu_enabled: got alu=%0h ill=%0b op2=%0b cnt=%0d in_ready=%0b required a/0/0/3/1",
                     alu_ctrl2, illegal2, op2_sel2, ill_count2, in_ready2);
        end
        checks++;
        if (out_valid2 !== 1'b1 || op1_sel2 !== 1'b0 || imm_out2 !== 32'h0) begin
            errors++;
            $display("FAIL sltu_enabled_payload: got valid=%0b op1=%0b imm=%08h required 1/0/0", out_valid2, op1_sel2, imm_out2);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_sub();
        test_stall();
        test_sltu_flush();
        test_back_to_back();
        test_reset_mid_stall();
        test_saturate();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending entries required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
